vending_fsm_param: RTL and testbench



---
 rtl/vending_pkg.sv | 26 ++
 rtl/vending_payout.sv | 61 ++++++
 rtl/vending_fsm_param.sv | 184 ++++++++++++++++++
 tb/tb_vending_fsm_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the parametrised vending controller.
//   state_t       : controller states (IDLE, CREDIT, PAYOUT)
//   COIN1/2/5     : token values in cents
//   credit_width  : width needed to hold the largest credit (price + 4)
// ---------------------------------------------------------------------------
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        PAYOUT = 2'd2
    } state_t;

    localparam int COIN1 = 1;
    localparam int COIN2 = 2;
    localparam int COIN5 = 5;

    // Largest credit ever held is price-1 plus a 5-cent token, so price+4.
    // $clog2(price+5) bits covers values 0..price+4.
    function automatic int credit_width(input int price);
        return $clog2(price + 5);
    endfunction

endpackage

// File: rtl/vending_payout.sv
// ---------------------------------------------------------------------------
// vending_payout
// Loadable down-counter that emits one 1-cent payout pulse per cycle until
// the loaded amount has been paid.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture amount as the new remainder
//   amount       : cents to pay out
//   busy         : payout in progress (registered)
//   pulse        : pay one cent this cycle (registered)
//   remaining    : cents still to be counted down; the controller uses it
//                  to leave its payout state on the final cent
// ---------------------------------------------------------------------------
module vending_payout #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] amount,
    output logic         busy,
    output logic         pulse,
    output logic [W-1:0] remaining
);

    logic [W-1:0] rem_q, rem_d;
    logic         pulse_q, pulse_d;
    logic         busy_q, busy_d;

    // A cent is paid for every cycle the remainder is non-zero; the pulse is
    // registered, so it trails the remainder by one cycle.
    always_comb begin
        rem_d   = rem_q;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (load) begin
            rem_d = amount;
        end else if (rem_q != '0) begin
            rem_d   = rem_q - W'(1);
            pulse_d = 1'b1;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign pulse     = pulse_q;
    assign remaining = rem_q;

endmodule

// File: rtl/vending_fsm_param.sv
// ---------------------------------------------------------------------------
// vending_fsm_param
// Parametrised vending controller: accepts 1/2/5-cent tokens, vends when the
// credit reaches PRICE, pays change (or a cancelled credit) back as a stream
// of 1-cent pulses, flags rejected tokens and counts vends (saturating).
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   one, two, five    : token inputs, one-cycle pulses from the acceptor
//   cancel            : refund request for the current credit
//   d                 : dispense pulse
//   refund            : refund-start pulse
//   r                 : change/refund amount, held until the next vend/refund
//   chg_pulse         : pay one cent this cycle
//   busy              : payout in progress
//   coin_rej          : a token was rejected last cycle
//   credit            : current accumulated credit
//   vend_cnt          : saturating vend counter
// ---------------------------------------------------------------------------
module vending_fsm_param
    import vending_pkg::*;
#(
    parameter  int PRICE    = 5,
    parameter  int CNT_W    = 8,
    localparam int CREDIT_W = credit_width(PRICE)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                one,
    input  logic                two,
    input  logic                five,
    input  logic                cancel,
    output logic                d,
    output logic                refund,
    output logic [CREDIT_W-1:0] r,
    output logic                chg_pulse,
    output logic                busy,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    vend_cnt
);

    if (PRICE < 1 || PRICE > 250) begin : g_price_check
        $error("vending_fsm_param: PRICE must be in the range 1..250");
    end

    localparam logic [CREDIT_W:0] PRICE_V = (CREDIT_W + 1)'(PRICE);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   r_q, r_d;
    logic                  d_q, d_d;
    logic                  refund_q, refund_d;
    logic                  coin_rej_q, coin_rej_d;
    logic [CNT_W-1:0]      vend_cnt_q, vend_cnt_d;

    logic                  coin_valid;
    logic                  coin_multi;
    logic [CREDIT_W:0]     coin_value;
    logic [CREDIT_W:0]     sum;
    logic [CREDIT_W-1:0]   change;

    logic                  pay_load;
    logic [CREDIT_W-1:0]   pay_amount;
    logic [CREDIT_W-1:0]   pay_remaining;

    // Token selection: one beats two beats five. Any additional asserted
    // token is the one the acceptor has to hand back.
    always_comb begin
        coin_valid = one | two | five;
        coin_multi = (one & two) | (one & five) | (two & five);
        if (one) begin
            coin_value = (CREDIT_W + 1)'(COIN1);
        end else if (two) begin
            coin_value = (CREDIT_W + 1)'(COIN2);
        end else if (five) begin
            coin_value = (CREDIT_W + 1)'(COIN5);
        end else begin
            coin_value = '0;
        end
    end

    // The extra sum bit guarantees credit + 5 never wraps before comparison.
    assign sum    = {1'b0, credit_q} + coin_value;
    assign change = CREDIT_W'(sum - PRICE_V);

    // Next-state logic. During payout every token is bounced; the state is
    // left on the final cent so the remainder reaches zero on the same edge.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        r_d        = r_q;
        d_d        = 1'b0;
        refund_d   = 1'b0;
        coin_rej_d = 1'b0;
        vend_cnt_d = vend_cnt_q;
        pay_load   = 1'b0;
        pay_amount = '0;

        case (state_q)
            IDLE, CREDIT: begin
                if (state_q == CREDIT && cancel) begin
                    // Cancel takes priority; a coin arriving with it is bounced.
                    refund_d   = 1'b1;
                    r_d        = credit_q;
                    credit_d   = '0;
                    pay_load   = 1'b1;
                    pay_amount = credit_q;
                    coin_rej_d = coin_valid;
                    state_d    = PAYOUT;
                end else if (coin_valid) begin
                    coin_rej_d = coin_multi;
                    if (sum < PRICE_V) begin
                        credit_d = CREDIT_W'(sum);
                        state_d  = CREDIT;
                    end else begin
                        d_d      = 1'b1;
                        r_d      = change;
                        credit_d = '0;
                        if (vend_cnt_q != {CNT_W{1'b1}}) begin
                            vend_cnt_d = vend_cnt_q + CNT_W'(1);
                        end
                        if (change != '0) begin
                            pay_load   = 1'b1;
                            pay_amount = change;
                            state_d    = PAYOUT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            PAYOUT: begin
                coin_rej_d = coin_valid;
                if (pay_remaining <= CREDIT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All controller state and outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            r_q        <= '0;
            d_q        <= 1'b0;
            refund_q   <= 1'b0;
            coin_rej_q <= 1'b0;
            vend_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            r_q        <= r_d;
            d_q        <= d_d;
            refund_q   <= refund_d;
            coin_rej_q <= coin_rej_d;
            vend_cnt_q <= vend_cnt_d;
        end
    end

    vending_payout #(
        .W(CREDIT_W)
    ) u_payout (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pay_load),
        .amount    (pay_amount),
        .busy      (busy),
        .pulse     (chg_pulse),
        .remaining (pay_remaining)
    );

    assign d        = d_q;
    assign refund   = refund_q;
    assign r        = r_q;
    assign coin_rej = coin_rej_q;
    assign credit   = credit_q;
    assign vend_cnt = vend_cnt_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// ---------------------------------------------------------------------------
// tb_vending_fsm_param
// Self-checking bench for vending_fsm_param (PRICE=5, CNT_W=2). A cent-level
// reference model tracks credit, owed change and the vend count; every cycle
// all outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_vending_fsm_param;

    localparam int TB_PRICE    = 5;
    localparam int TB_CNT_W    = 2;
    localparam int TB_CREDIT_W = $clog2(TB_PRICE + 5);
    localparam int TB_CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   one, two, five, cancel;
    logic                   d, refund, chg_pulse, busy, coin_rej;
    logic [TB_CREDIT_W-1:0] r, credit;
    logic [TB_CNT_W-1:0]    vend_cnt;

    int tests      = 0;
    int failures   = 0;
    int pulse_seen = 0;

    // Reference model: money owed back to the customer is paid one cent per
    // cycle, and while anything is owed no token is taken.
    int m_credit, m_r, m_cnt, m_owed;
    bit m_d, m_refund, m_rej, m_pulse;

    vending_fsm_param #(
        .PRICE(TB_PRICE),
        .CNT_W(TB_CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .one       (one),
        .two       (two),
        .five      (five),
        .cancel    (cancel),
        .d         (d),
        .refund    (refund),
        .r         (r),
        .chg_pulse (chg_pulse),
        .busy      (busy),
        .coin_rej  (coin_rej),
        .credit    (credit),
        .vend_cnt  (vend_cnt)
    );

    always #5 clk = ~clk;

    // Generous time limit so a broken run still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        m_credit = 0;
        m_r      = 0;
        m_cnt    = 0;
        m_owed   = 0;
        m_d      = 0;
        m_refund = 0;
        m_rej    = 0;
        m_pulse  = 0;
    endtask

    // One clock of customer activity at the level of cents and tokens.
    task automatic modelStep(input bit i1, input bit i2, input bit i5, input bit ic);
        int tokens;
        int value;
        tokens   = int'(i1) + int'(i2) + int'(i5);
        m_d      = 0;
        m_refund = 0;
        m_rej    = 0;
        m_pulse  = 0;
        if (m_owed > 0) begin
            m_pulse = 1;
            m_owed  = m_owed - 1;
            m_rej   = (tokens > 0);
        end else if (ic && m_credit > 0) begin
            m_refund = 1;
            m_r      = m_credit;
            m_owed   = m_credit;
            m_credit = 0;
            m_rej    = (tokens > 0);
        end else if (tokens > 0) begin
            value = i1 ? 1 : (i2 ? 2 : 5);
            m_rej = (tokens > 1);
            if (m_credit + value >= TB_PRICE) begin
                m_d      = 1;
                m_r      = m_credit + value - TB_PRICE;
                m_owed   = m_r;
                m_credit = 0;
                if (m_cnt < TB_CNT_MAX) m_cnt = m_cnt + 1;
            end else begin
                m_credit = m_credit + value;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests = tests + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/d"},         int'(d),         int'(m_d));
        checkOutput({tag, "/refund"},    int'(refund),    int'(m_refund));
        checkOutput({tag, "/r"},         int'(r),         m_r);
        checkOutput({tag, "/chg_pulse"}, int'(chg_pulse), int'(m_pulse));
        checkOutput({tag, "/busy"},      int'(busy),      int'(m_pulse));
        checkOutput({tag, "/coin_rej"},  int'(coin_rej),  int'(m_rej));
        checkOutput({tag, "/credit"},    int'(credit),    m_credit);
        checkOutput({tag, "/vend_cnt"},  int'(vend_cnt),  m_cnt);
    endtask

    // Drive one cycle of inputs, step the model at the edge, check 1ns later.
    task automatic applyStimulus(input bit i1, input bit i2, input bit i5, input bit ic,
                                 input string tag);
        one    = i1;
        two    = i2;
        five   = i5;
        cancel = ic;
        @(posedge clk);
        modelStep(i1, i2, i5, ic);
        #1;
        checkAll(tag);
        if (chg_pulse) pulse_seen = pulse_seen + 1;
    endtask

    task automatic runIdle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, tag);
    endtask

    // Asynchronous reset applied between clock edges and checked before the
    // next edge arrives.
    task automatic doReset(input string tag);
        #2;
        reset_n = 1'b0;
        one     = 1'b0;
        two     = 1'b0;
        five    = 1'b0;
        cancel  = 1'b0;
        #1;
        modelReset();
        checkAll(tag);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset_n = 1'b0;
        one     = 1'b0;
        two     = 1'b0;
        five    = 1'b0;
        cancel  = 1'b0;
        modelReset();
        #2;
        checkAll("reset");
        #6;
        reset_n = 1'b1;

        // Exact payment: 1 + 2 + 2.
        pulse_seen = 0;
        applyStimulus(1, 0, 0, 0, "t1_one");
        applyStimulus(0, 1, 0, 0, "t1_two");
        applyStimulus(0, 1, 0, 0, "t1_vend");
        checkOutput("t1_d", int'(d), 1);
        runIdle(3, "t1_idle");
        checkOutput("t1_pulses", pulse_seen, 0);

        // Overpayment: 2 + 2 + 5 leaves 4 cents of change.
        pulse_seen = 0;
        applyStimulus(0, 1, 0, 0, "t2_two");
        applyStimulus(0, 1, 0, 0, "t2_two");
        applyStimulus(0, 0, 1, 0, "t2_vend");
        checkOutput("t2_r", int'(r), 4);
        runIdle(6, "t2_payout");
        checkOutput("t2_pulses", pulse_seen, 4);

        // Cancel after 2 + 1 refunds 3 cents.
        pulse_seen = 0;
        applyStimulus(0, 1, 0, 0, "t3_two");
        applyStimulus(1, 0, 0, 0, "t3_one");
        applyStimulus(0, 0, 0, 1, "t3_cancel");
        checkOutput("t3_refund_r", int'(r), 3);
        runIdle(5, "t3_payout");
        checkOutput("t3_pulses", pulse_seen, 3);

        // Token during payout is bounced without disturbing the payout.
        pulse_seen = 0;
        applyStimulus(0, 1, 0, 0, "t4_two");
        applyStimulus(0, 1, 0, 0, "t4_two");
        applyStimulus(0, 0, 1, 0, "t4_vend");
        applyStimulus(0, 1, 0, 0, "t4_coin_in_payout");
        applyStimulus(0, 0, 0, 0, "t4_rej");
        checkOutput("t4_rej_flag_seen", int'(credit), 0);
        runIdle(5, "t4_payout");
        checkOutput("t4_pulses", pulse_seen, 4);

        // one and five together from idle: the one is kept, the five bounced.
        applyStimulus(1, 0, 1, 0, "t4_one_five");
        checkOutput("t4_one_five_credit", int'(credit), 1);
        checkOutput("t4_one_five_rej", int'(coin_rej), 1);
        applyStimulus(0, 0, 0, 1, "t4_clear");
        runIdle(3, "t4_drain");

        // Cancel together with a two while holding 4 cents.
        applyStimulus(0, 1, 0, 0, "t5_two");
        applyStimulus(0, 1, 0, 0, "t5_two");
        applyStimulus(0, 1, 0, 1, "t5_cancel_two");
        checkOutput("t5_r", int'(r), 4);
        checkOutput("t5_rej", int'(coin_rej), 1);
        runIdle(6, "t5_payout");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, "rand");
        end
        runIdle(10, "rand_drain");

        // Vend counter saturation with a 2-bit counter.
        doReset("t6_reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, "t6_vend");
            checkOutput("t6_vend_sat", int'(vend_cnt), sat_exp[i]);
        end

        // Reset in the middle of a payout abandons the remaining change.
        applyStimulus(0, 1, 0, 0, "t6_two");
        applyStimulus(0, 1, 0, 0, "t6_two");
        applyStimulus(0, 0, 1, 0, "t6_vend_change");
        runIdle(2, "t6_paying");
        doReset("t6_mid_payout_reset");
        pulse_seen = 0;
        runIdle(6, "t6_after_reset");
        checkOutput("t6_no_pulses", pulse_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
